// File: rtl/shifter_pkg.sv
// Shared types and helper constants for the pipelined arithmetic shifter.
package shifter_pkg;

  // Shift modes as carried on in_mode.
  typedef enum logic [1:0] {
    SH_RTRUNC = 2'b00,  // arithmetic right shift, floor
    SH_RROUND = 2'b01,  // arithmetic right shift, round half up
    SH_LSAT   = 2'b10,  // left shift, clamp on overflow
    SH_LWRAP  = 2'b11   // left shift, modulo 2^WIDTH
  } sh_mode_e;

  // Default geometry used by the neuron datapath.
  localparam int DEF_WIDTH   = 21;
  localparam int DEF_SHAMT_W = 5;
  localparam int DEF_TAG_W   = 4;

  // Largest positive two's-complement value for a w-bit word.
  function automatic longint max_pos(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  // Most negative two's-complement value for a w-bit word.
  function automatic longint min_neg(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Valid/ready operand and result channels of the pipelined shifter.
interface pipelined_shifter_if #(
  parameter int WIDTH   = 21,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 4
);

  // Operand channel.
  logic                      in_valid;
  logic                      in_ready;
  logic signed [WIDTH-1:0]   in_data;
  logic        [SHAMT_W-1:0] in_shamt;
  logic        [1:0]         in_mode;
  logic        [TAG_W-1:0]   in_tag;

  // Result channel.
  logic                      out_valid;
  logic                      out_ready;
  logic signed [WIDTH-1:0]   out_data;
  logic                      out_sat;
  logic        [TAG_W-1:0]   out_tag;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_tag
  );

  // The shifter itself.
  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_tag
  );

endinterface

// File: rtl/shift_core.sv
// Combinational shift core: raw shifted value, rounding bit and overflow
// flag for one operand. The final increment/clamp is applied downstream.
module shift_core
  import shifter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic signed [WIDTH-1:0]   a,
  input  logic        [SHAMT_W-1:0] shamt,
  input  sh_mode_e                  mode,
  output logic signed [WIDTH-1:0]   raw,
  output logic                      round_bit,
  output logic                      ovf
);

  logic                    big;        // shift amount reaches or exceeds WIDTH
  logic signed [WIDTH-1:0] sra;        // a >>> shamt, sign-filled
  logic signed [WIDTH-1:0] shl;        // a << shamt, truncated
  logic        [WIDTH-1:0] half_mask;  // selects bit shamt-1 of a

  assign big       = (32'(shamt) >= 32'(WIDTH));
  assign sra       = a >>> shamt;
  assign shl       = a << shamt;
  assign half_mask = {{(WIDTH-1){1'b0}}, 1'b1} << (shamt - SHAMT_W'(1));

  // Select the raw result and side bits for the requested mode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (otherwise synthesis infers a latch).
    raw       = '0;
    round_bit = 1'b0;
    ovf       = 1'b0;
    unique case (mode)
      SH_RTRUNC: begin
        // Shifting by >= WIDTH already yields 0 or -1 from the sign fill.
        raw = sra;
      end
      SH_RROUND: begin
        if (!big) begin
          raw       = sra;
          round_bit = (shamt != '0) && ((a & half_mask) != '0);
        end
      end
      SH_LSAT: begin
        raw = shl;
        // Overflow when the shift cannot be undone: the discarded top bits
        // were not all copies of the sign.
        ovf = big ? (a != '0) : ((shl >>> shamt) != a);
      end
      SH_LWRAP: begin
        raw = big ? '0 : shl;
      end
      default: begin
        raw = '0;
      end
    endcase
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Two-stage pipelined signed shifter with valid/ready flow control.
// S1 holds the operand and feeds the shift core; S2 holds the finished
// (rounded or saturated) result and drives the output channel.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  pipelined_shifter_if.slave bus
);

  localparam logic signed [WIDTH-1:0] MAX_POS = WIDTH'(max_pos(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN_NEG = WIDTH'(min_neg(WIDTH));

  // Stage S1: captured operand.
  logic                      s1_valid;
  logic signed [WIDTH-1:0]   s1_data;
  logic        [SHAMT_W-1:0] s1_shamt;
  sh_mode_e                  s1_mode;
  logic        [TAG_W-1:0]   s1_tag;

  // Stage S2: finished result.
  logic                      s2_valid;
  logic signed [WIDTH-1:0]   s2_data;
  logic                      s2_sat;
  logic        [TAG_W-1:0]   s2_tag;

  // Shift core outputs and the S2 input they produce.
  logic signed [WIDTH-1:0]   core_raw;
  logic                      core_round;
  logic                      core_ovf;
  logic signed [WIDTH-1:0]   s2_next_data;
  logic                      s2_next_sat;

  // Stage advance enables; a stage may load when it is empty or draining.
  logic adv1;
  logic adv2;

  // in_ready depends combinationally on out_ready so a full pipeline still
  // accepts a new operand in the same cycle the result is taken.
  assign adv2         = !s2_valid || bus.out_ready;
  assign adv1         = !s1_valid || adv2;
  assign bus.in_ready = adv1;

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_sat   = s2_sat;
  assign bus.out_tag   = s2_tag;

  // S1 register: accept a new operand whenever the stage can advance.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the data registers are reset as well as the valid bits, so the
    // outputs read as zero during reset rather than holding stale values.
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_shamt <= '0;
      s1_mode  <= SH_RTRUNC;
      s1_tag   <= '0;
    end else if (adv1) begin
      // NOTE: sequential state is written with non-blocking assignments so
      // every register samples pre-edge values regardless of block order.
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data  <= bus.in_data;
        s1_shamt <= bus.in_shamt;
        s1_mode  <= sh_mode_e'(bus.in_mode);
        s1_tag   <= bus.in_tag;
      end
    end
  end

  shift_core #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .a         (s1_data),
    .shamt     (s1_shamt),
    .mode      (s1_mode),
    .raw       (core_raw),
    .round_bit (core_round),
    .ovf       (core_ovf)
  );

  // Finish the S1 result: add the rounding bit or clamp on overflow.
  always_comb begin
    s2_next_data = core_raw;
    s2_next_sat  = 1'b0;
    unique case (s1_mode)
      SH_RROUND: begin
        // Cannot overflow: a right shift by >= 1 leaves headroom for +1.
        s2_next_data = core_raw + WIDTH'(core_round);
      end
      SH_LSAT: begin
        if (core_ovf) begin
          s2_next_data = s1_data[WIDTH-1] ? MIN_NEG : MAX_POS;
          s2_next_sat  = 1'b1;
        end
      end
      default: begin
        s2_next_data = core_raw;
      end
    endcase
  end

  // S2 register: take the S1 result when the output is free or being drained;
  // otherwise hold so out_* stay stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_sat   <= 1'b0;
      s2_tag   <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= s2_next_data;
        s2_sat  <= s2_next_sat;
        s2_tag  <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter: directed vector table,
// backpressure, streaming, mid-flight reset and randomized traffic against a
// behavioural arithmetic model.
module tb_pipelined_shifter;
  import shifter_pkg::*;

  localparam int W  = 21;
  localparam int SW = 5;
  localparam int TW = 4;
  localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W - 1));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_shifter_if #(.WIDTH(W), .SHAMT_W(SW), .TAG_W(TW)) bus ();

  pipelined_shifter #(.WIDTH(W), .SHAMT_W(SW), .TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint wrap_w(input longint x);
    longint y;
    y = x & ((longint'(1) <<< W) - 1);
    if (y > MAXV) y = y - (longint'(1) <<< W);
    return y;
  endfunction

  function automatic void model(input longint a, input int s, input int m,
                                output longint r, output bit sat);
    longint p;
    longint prod;
    p   = longint'(1) <<< s;
    sat = 1'b0;
    r   = 0;
    case (m)
      0: r = (s >= W) ? ((a < 0) ? -1 : 0) : floor_div(a, p);
      1: r = (s == 0) ? a : ((s >= W) ? 0 : floor_div(a + p / 2, p));
      2: begin
        if (s >= W) begin
          r   = (a == 0) ? 0 : ((a > 0) ? MAXV : MINV);
          sat = (a != 0);
        end else begin
          prod = a * p;
          if (prod > MAXV)      begin r = MAXV; sat = 1'b1; end
          else if (prod < MINV) begin r = MINV; sat = 1'b1; end
          else r = prod;
        end
      end
      default: r = (s >= W) ? 0 : wrap_w(a * p);
    endcase
  endfunction

  // ---------------- operand list and driver ----------------
  longint op_a[256];
  int     op_s[256];
  int     op_m[256];
  int     op_t[256];
  int     n_ops;
  int     sent;
  int     got;

  task automatic present();
    if (sent < n_ops) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'(op_a[sent]);
      bus.in_shamt = SW'(op_s[sent]);
      bus.in_mode  = 2'(op_m[sent]);
      bus.in_tag   = TW'(op_t[sent]);
    end else begin
      bus.in_valid = 1'b0;
      bus.in_data  = W'($urandom);
    end
  endtask

  task automatic gen_random(input int n);
    logic signed [W-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = W'($urandom);
      case ($urandom_range(3))
        0: op_a[i] = v;
        1: op_a[i] = longint'($urandom_range(128)) - 64;
        2: op_a[i] = ($urandom_range(1) == 1) ? MAXV : MINV;
        default: op_a[i] = v >>> $urandom_range(W - 1);
      endcase
      op_s[i] = $urandom_range(31);
      op_m[i] = $urandom_range(3);
      op_t[i] = $urandom_range(15);
    end
    n_ops = n;
    sent  = 0;
    got   = 0;
  endtask

  // Compare the current output against the model result for operand got.
  task automatic check_out(input int idx);
    longint r;
    bit     sat;
    model(op_a[idx], op_s[idx], op_m[idx], r, sat);
    check($sformatf("op%0d data", idx), longint'(bus.out_data), r);
    check($sformatf("op%0d sat", idx), longint'(bus.out_sat), longint'(sat));
    check($sformatf("op%0d tag", idx), longint'(bus.out_tag), longint'(op_t[idx]));
  endtask

  // Run the operand list to completion with random valid/ready duty (percent).
  // Entered and left #1 after a rising edge.
  task automatic run_ops(input int p_valid, input int p_ready, input int budget);
    int                  cyc;
    bit                  acc;
    bit                  stall_prev;
    logic signed [W-1:0] snap_data;
    logic                snap_sat;
    logic [TW-1:0]       snap_tag;
    cyc        = 0;
    stall_prev = 1'b0;
    snap_data  = '0;
    snap_sat   = 1'b0;
    snap_tag   = '0;
    while (got < n_ops && cyc < budget) begin
      if (sent < n_ops && $urandom_range(99) < p_valid) present();
      else bus.in_valid = 1'b0;
      bus.out_ready = ($urandom_range(99) < p_ready);
      @(negedge clk);
      if (stall_prev) begin
        check("stall valid", longint'(bus.out_valid), 1);
        check("stall data", longint'(bus.out_data), longint'(snap_data));
        check("stall sat", longint'(bus.out_sat), longint'(snap_sat));
        check("stall tag", longint'(bus.out_tag), longint'(snap_tag));
      end
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        if (got < n_ops) check_out(got);
        else check("extra result", 1, 0);
        got++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      snap_data  = bus.out_data;
      snap_sat   = bus.out_sat;
      snap_tag   = bus.out_tag;
      @(posedge clk);
      #1;
      if (acc) sent++;
      cyc++;
    end
    if (got < n_ops) check("result timeout", longint'(got), longint'(n_ops));
    bus.in_valid = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    longint a;
    int     s;
    int     m;
    int     tag;
    longint exp;
    bit     exp_sat;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int                  w;
    int                  valid_cnt;
    logic signed [W-1:0] sd;
    logic [TW-1:0]       st;

    vecs[0]  = '{-14,    2,  0, 1,  -4,       1'b0};
    vecs[1]  = '{-14,    2,  1, 2,  -3,       1'b0};
    vecs[2]  = '{13,     2,  0, 3,  3,        1'b0};
    vecs[3]  = '{13,     2,  1, 4,  3,        1'b0};
    vecs[4]  = '{-13,    0,  1, 5,  -13,      1'b0};
    vecs[5]  = '{12288,  7,  2, 6,  1048575,  1'b1};
    vecs[6]  = '{12288,  7,  3, 7,  -524288,  1'b0};
    vecs[7]  = '{-12288, 7,  2, 8,  -1048576, 1'b1};
    vecs[8]  = '{100,    3,  2, 9,  800,      1'b0};
    vecs[9]  = '{-5,     25, 0, 10, -1,       1'b0};
    vecs[10] = '{5,      25, 0, 11, 0,        1'b0};
    vecs[11] = '{-5,     25, 1, 12, 0,        1'b0};
    vecs[12] = '{1,      25, 2, 13, 1048575,  1'b1};
    vecs[13] = '{0,      25, 2, 14, 0,        1'b0};
    vecs[14] = '{12345,  25, 3, 15, 0,        1'b0};
    vecs[15] = '{-1,     20, 2, 0,  -1048576, 1'b0};
    vecs[16] = '{1,      20, 2, 1,  1048575,  1'b1};
    vecs[17] = '{-1,     20, 1, 2,  0,        1'b0};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_mode   = 2'b00;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    n_ops = 0;
    sent  = 0;
    got   = 0;

    // Reset state.
    rst = 1'b0;
    #2 rst = 1'b1;
    #2;
    check("reset out_valid", longint'(bus.out_valid), 0);
    check("reset out_data", longint'(bus.out_data), 0);
    check("reset out_sat", longint'(bus.out_sat), 0);
    check("reset out_tag", longint'(bus.out_tag), 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready after reset", longint'(bus.in_ready), 1);

    // Directed vectors, one at a time.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'(vecs[i].a);
      bus.in_shamt = SW'(vecs[i].s);
      bus.in_mode  = 2'(vecs[i].m);
      bus.in_tag   = TW'(vecs[i].tag);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      w = 0;
      @(negedge clk);
      while (!bus.out_valid && w < 4) begin
        @(negedge clk);
        w++;
      end
      if (!bus.out_valid) begin
        check($sformatf("vec%0d timeout", i), 0, 1);
      end else begin
        check($sformatf("vec%0d data", i), longint'(bus.out_data), vecs[i].exp);
        check($sformatf("vec%0d sat", i), longint'(bus.out_sat), longint'(vecs[i].exp_sat));
        check($sformatf("vec%0d tag", i), longint'(bus.out_tag), longint'(vecs[i].tag));
      end
      @(posedge clk);
      #1;
    end

    // Backpressure: four operands offered with out_ready low.
    gen_random(4);
    bus.out_ready = 1'b0;
    sd = '0;
    st = '0;
    for (int c = 0; c < 6; c++) begin
      bit acc;
      present();
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (c == 2) begin
        check("bp first valid", longint'(bus.out_valid), 1);
        check_out(0);
        sd = bus.out_data;
        st = bus.out_tag;
      end
      if (c > 2) begin
        check("bp hold valid", longint'(bus.out_valid), 1);
        check("bp hold data", longint'(bus.out_data), longint'(sd));
        check("bp hold tag", longint'(bus.out_tag), longint'(st));
        check("bp in_ready low", longint'(bus.in_ready), 0);
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    check("bp accepted while stalled", longint'(sent), 2);
    run_ops(100, 100, 40);

    // Streaming: eight operands, no bubbles, one-edge latency after capture.
    gen_random(8);
    bus.out_ready = 1'b1;
    present();
    @(negedge clk);
    check("stream first in_ready", longint'(bus.in_ready), 1);
    check("stream idle out_valid", longint'(bus.out_valid), 0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (sent < n_ops) sent++;
      present();
      @(negedge clk);
      check($sformatf("stream c%0d out_valid", c), longint'(bus.out_valid),
            (c >= 1 && c <= 8) ? 1 : 0);
      if (c >= 1 && c <= 8 && bus.out_valid) check_out(c - 1);
      if (bus.in_valid) check($sformatf("stream c%0d in_ready", c), longint'(bus.in_ready), 1);
    end
    @(posedge clk);
    #1;

    // Reset with two operands in flight.
    n_ops = 2;
    sent  = 0;
    got   = 0;
    op_a[0] = 1;  op_s[0] = 25; op_m[0] = 2; op_t[0] = 9;
    op_a[1] = -3; op_s[1] = 4;  op_m[1] = 0; op_t[1] = 5;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      present();
      @(posedge clk);
      #1;
      sent++;
    end
    bus.in_valid = 1'b0;
    check("pre-reset out_valid", longint'(bus.out_valid), 1);
    check("pre-reset out_sat", longint'(bus.out_sat), 1);
    #2 rst = 1'b1;
    #1;
    check("mid reset out_valid", longint'(bus.out_valid), 0);
    check("mid reset out_data", longint'(bus.out_data), 0);
    check("mid reset out_sat", longint'(bus.out_sat), 0);
    check("mid reset out_tag", longint'(bus.out_tag), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post reset in_ready", longint'(bus.in_ready), 1);
    n_ops = 1;
    sent  = 0;
    got   = 0;
    op_a[0] = -100; op_s[0] = 3; op_m[0] = 1; op_t[0] = 6;
    run_ops(100, 100, 20);
    bus.out_ready = 1'b1;
    valid_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.out_valid) valid_cnt++;
    end
    check("no stale result", longint'(valid_cnt), 0);
    @(posedge clk);
    #1;

    // Randomized traffic with random stalls on both sides.
    gen_random(200);
    run_ops(70, 70, 3000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined, signed arithmetic shifter for the neuron datapath. Successor to the fixed-width combinational shifter.
- Accepts any shift amount, supports four modes (truncating/rounding right, saturating/wrapping left), and carries a sideband tag.
- Sits between the weighted-sum accumulator and the activation/normalisation stage. Uses valid/ready handshakes on both sides so upstream stalls propagate cleanly.

Parameters:
- WIDTH, 21: signed operand and result width.
- SHAMT_W, 5: shift-amount width. Values ≥ WIDTH are legal.
- TAG_W, 4: width of the opaque sideband tag passed through with each operand.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- in_data  in  WIDTH  signed operand, two's complement.
- in_shamt  in  SHAMT_W  shift amount, unsigned.
- in_mode  in  2  shift mode: 00 right truncate, 01 right round-half-up, 10 left saturate, 11 left wrap.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  signed result.
- out_sat  out  1  result was clamped (mode 10 only).
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - s1_valid and s2_valid clear immediately; all in-flight operands are discarded.
  - out_valid=0, out_data=0, out_sat=0, out_tag=0.
  - in_ready=1 from the first clock after rst deasserts.
- Pipeline: two register stages, S1 and S2. S2 drives the outputs.
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1. This is a combinational path from out_ready, which is intentional.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Latency and ordering:
  - An operand captured at edge N has out_valid high from edge N+1 onward.
  - Throughput is 1 per cycle when out_ready stays high.
  - Order is strictly preserved.
  - Maximum occupancy is 2 operands.
- S1 operations: registers operand, shamt, mode and tag, then computes the raw shift and the overflow/round bits.
- S2 operations: applies the rounding increment or saturation.
- Stall rules:
  - A held stage keeps its contents stable.
  - out_* must not change while out_valid && !out_ready.
- Simultaneous events: an input transfer and an output transfer in the same cycle are both honoured; occupancy is unchanged.
- Arithmetic, with s = in_shamt and all results WIDTH bits:
  - Mode 00: result = a >>> s (floor). For s ≥ WIDTH, result = -1 if a<0, else 0.
  - Mode 01: result = (a >>> s) + a[s-1] for 1 ≤ s < WIDTH. This cannot overflow. For s=0, result = a. For s ≥ WIDTH, result = 0.
  - Mode 10 (left saturate): result = a << s if bits [WIDTH-1 : WIDTH-1-s] of a all equal the sign. Otherwise clamp to MAX=2^(WIDTH-1)-1 (a>0) or MIN=-2^(WIDTH-1) (a<0), and set out_sat=1.
    - For s ≥ WIDTH: a=0 gives 0 with sat=0; any other a clamps.
  - Mode 11: result = (a << s) truncated to WIDTH bits; 0 for s ≥ WIDTH. sat=0.
  - out_sat=0 in all modes other than 10.
- Unknown or X values on in_data are don't-care only when in_valid=0.

Decomposition:
- Package shifter_pkg:
  - Mode enum: SH_RTRUNC=2'b00, SH_RROUND=2'b01, SH_LSAT=2'b10, SH_LWRAP=2'b11.
  - Helper constants: MAX_POS/MIN_NEG as functions of WIDTH.
- One natural sub-module: shift_core. It is purely combinational: raw shift, round bit and overflow detect for a given mode. It is instantiated in S1.
- Handshake and register logic stay in pipelined_shifter.

Test Plan (WIDTH=21):
- Right modes: a=-14, s=2. Mode 00 gives -4; mode 01 gives -3. a=13, s=2: mode 00 gives 3; mode 01 gives 3. a=-13, s=0, mode 01 gives -13.
- Left modes: a=12288, s=7. Mode 10 gives 1048575 with sat=1. Mode 11 gives -524288 with sat=0. a=-12288, s=7, mode 10 gives -1048576 with sat=1. a=100, s=3, mode 10 gives 800 with sat=0.
- Large shamt: s=25.
  - Mode 00: a=-5 gives -1; a=5 gives 0.
  - Mode 01: a=-5 gives 0.
  - Mode 10: a=1 gives 1048575 with sat=1; a=0 gives 0 with sat=0.
  - Mode 11 gives 0.
- Backpressure: offer 4 back-to-back operands with out_ready=0. Exactly 2 are accepted, in_ready goes low, and out_* are stable. Raise out_ready: the remaining 2 are accepted, and all 4 emerge in order with matching tags.
- Streaming: 8 operands with in_valid=1 and out_ready=1. First out_valid is 1 edge after the first capture, then one result per cycle with no bubbles.
- Reset mid-flight: assert rst asynchronously (between edges) with 2 operands in flight. out_valid drops immediately and outputs are zero. After release, the next operand completes normally and no stale result appears.
